// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory size
// default and requester port indices.
package dmem_pkg;

  localparam int unsigned MEM_BYTES_DEF = 512;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the port that was not granted last.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_valid,
  output logic o_winner
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = PORT_CPU;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last_gnt;
    end else if (i_req1) begin
      o_winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing the byte-addressed data memory between
// the CPU load/store port (0) and the debug/DMA loader (1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_RD,
  output logic              mem_WR,
  output logic [ADDR_W-1:0] mem_DAddr,
  output logic [DATA_W-1:0] mem_DataIn,
  input  logic [DATA_W-1:0] mem_DataOut
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t              r_state;
  logic                r_last_gnt;
  logic                r_owner;
  logic                r_lat_we;
  logic                r_lat_err;
  logic [ADDR_W-1:0]   r_lat_addr;
  logic [DATA_W-1:0]   r_lat_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_valid;
  logic                w_winner;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_addr_ok;

  rr_pick2 u_pick (
    .i_req0     (req0),
    .i_req1     (req1),
    .i_last_gnt (r_last_gnt),
    .o_valid    (w_valid),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_sel_we    = (w_winner == PORT_DBG) ? we1    : we0;
    w_sel_addr  = (w_winner == PORT_DBG) ? addr1  : addr0;
    w_sel_wdata = (w_winner == PORT_DBG) ? wdata1 : wdata0;
    w_addr_ok   = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr <= LAST_WORD);
  end

  // The address/data latches double as the memory bus drivers, so they are
  // only loaded on a legal grant and otherwise hold their last value.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_last_gnt  <= PORT_DBG;
      r_owner     <= PORT_CPU;
      r_lat_we    <= 1'b0;
      r_lat_err   <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner    <= w_winner;
            r_last_gnt <= w_winner;
            r_lat_we   <= w_sel_we;
            if (w_addr_ok) begin
              r_lat_addr  <= w_sel_addr;
              r_lat_wdata <= w_sel_wdata;
              r_state     <= ACCESS;
            end else begin
              r_lat_err <= 1'b1;
              r_rdata   <= '0;
              r_state   <= DONE;
            end
          end
        end
        ACCESS: begin
          r_rdata <= r_lat_we ? '0 : mem_DataOut;
          r_state <= DONE;
        end
        DONE: begin
          r_lat_err <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset kills a write before the
  // memory's falling-edge sample.
  always_comb begin
    mem_WR     = (r_state == ACCESS) &&  r_lat_we;
    mem_RD     = (r_state == ACCESS) && !r_lat_we;
    mem_DAddr  = r_lat_addr;
    mem_DataIn = r_lat_wdata;
    ack0       = (r_state == DONE) && (r_owner == PORT_CPU);
    ack1       = (r_state == DONE) && (r_owner == PORT_DBG);
    err        = (r_state == DONE) && r_lat_err;
    rdata      = r_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a byte-wide big-endian memory model.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, mem_RD, mem_WR;
  logic [31:0] rdata, mem_DAddr, mem_DataIn, mem_DataOut;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(512)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .mem_RD(mem_RD), .mem_WR(mem_WR), .mem_DAddr(mem_DAddr),
    .mem_DataIn(mem_DataIn), .mem_DataOut(mem_DataOut)
  );

  function automatic logic [7:0] pat(input int unsigned i);
    return 8'((i * 7) + 3);
  endfunction

  // Memory model: combinational big-endian read, write on falling edge.
  logic [7:0] mem [0:511];
  logic [8:0] w_a;
  assign w_a = mem_DAddr[8:0];
  assign mem_DataOut = {mem[w_a], mem[w_a + 9'd1], mem[w_a + 9'd2], mem[w_a + 9'd3]};

  initial begin
    for (int unsigned i = 0; i < 512; i++) mem[i] = pat(i);
    forever begin
      @(negedge CLK);
      if (mem_WR) begin
        mem[w_a]        = mem_DataIn[31:24];
        mem[w_a + 9'd1] = mem_DataIn[23:16];
        mem[w_a + 9'd2] = mem_DataIn[15:8];
        mem[w_a + 9'd3] = mem_DataIn[7:0];
      end
    end
  end

  int wr_cnt = 0, rd_cnt = 0, both_ack = 0, both_mem = 0;
  always @(negedge CLK) begin
    if (ack0 && ack1)     both_ack++;
    if (mem_RD && mem_WR) both_mem++;
    if (mem_WR)           wr_cnt++;
    if (mem_RD)           rd_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  logic [7:0] ref_mem [0:511];
  function automatic logic [31:0] ref_word(input int unsigned a);
    return {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
  endfunction

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[12];

  task automatic drive(input logic port, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (port) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else      begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: ack with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_port"},  32'(ack1),  32'(e.port));
      chk({nm, "_rdata"}, rdata,      e.rdata);
      chk({nm, "_err"},   32'(err),   32'(e.err));
    end
  endtask

  // Called at a falling edge with the arbiter idle; returns one edge after ack.
  task automatic do_txn(input vec_t v, input string nm);
    int  wr0, rd0, waited;
    bit  got;
    wr0 = wr_cnt; rd0 = rd_cnt; waited = 0; got = 0;
    sb.push_back('{port: v.port, rdata: v.exp_rdata, err: v.exp_err});
    drive(v.port, v.we, v.addr, v.wdata);
    while (!got && waited < 10) begin
      @(negedge CLK);
      waited++;
      if (ack0 || ack1) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no ack after %0d cycles, required one", nm, waited);
      sb.delete();
    end else begin
      chk({nm, "_lat"}, 32'(waited), v.exp_err ? 32'd1 : 32'd2);
      sb_check(nm);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);
    chk({nm, "_wrcyc"}, 32'(wr_cnt - wr0), 32'(!v.exp_err &&  v.we));
    chk({nm, "_rdcyc"}, 32'(rd_cnt - rd0), 32'(!v.exp_err && !v.we));
    if (!v.exp_err && v.we) begin
      ref_mem[v.addr[8:0]]        = v.wdata[31:24];
      ref_mem[v.addr[8:0] + 9'd1] = v.wdata[23:16];
      ref_mem[v.addr[8:0] + 9'd2] = v.wdata[15:8];
      ref_mem[v.addr[8:0] + 9'd3] = v.wdata[7:0];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack, waited, last;
    logic [31:0] w0, w4;
    for (int unsigned i = 0; i < 512; i++) ref_mem[i] = pat(i);

    Reset = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ack0", 32'(ack0), 0);     chk("rst_ack1", 32'(ack1), 0);
    chk("rst_err", 32'(err), 0);       chk("rst_rdata", rdata, 0);
    chk("rst_memrd", 32'(mem_RD), 0);  chk("rst_memwr", 32'(mem_WR), 0);
    chk("rst_daddr", mem_DAddr, 0);    chk("rst_datain", mem_DataIn, 0);
    Reset = 1'b1;
    @(negedge CLK);

    // Simultaneous saturated requests straight out of reset.
    w0 = ref_word(0); w4 = ref_word(4);
    for (int k = 0; k < 4; k++) sb.push_back('{port: 1'(k % 2), rdata: (k % 2) ? w4 : w0, err: 1'b0});
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h4, 32'h0);
    nack = 0; waited = 0; last = 0;
    while (nack < 4 && waited < 30) begin
      @(negedge CLK);
      waited++;
      if (ack0 || ack1) begin
        nack++;
        sb_check($sformatf("rr%0d", nack));
        chk($sformatf("rr%0d_cycle", nack), 32'(waited), (nack == 1) ? 32'd2 : 32'(last + 3));
        last = waited;
      end
    end
    req0 = 0; req1 = 0;
    chk("rr_count", 32'(nack), 4);
    sb.delete();
    @(negedge CLK);

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0022, 32'h0,         32'h0,         1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_01FC, 32'h1234_5678, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_01FC, 32'h0,         32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h5555_AAAA, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h6666_9999, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0201, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_01FD, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         ref_word(8),   1'b0};
    for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    chk("mem_20", 32'(mem[9'h20]), 32'hDE); chk("mem_21", 32'(mem[9'h21]), 32'hAD);
    chk("mem_22", 32'(mem[9'h22]), 32'hBE); chk("mem_23", 32'(mem[9'h23]), 32'hEF);

    // Reset asserted during the write's ACCESS cycle, before the falling edge.
    drive(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5);
    @(posedge CLK); #1;
    chk("midrst_wr_before", 32'(mem_WR), 1);
    #1 Reset = 1'b0;
    #1;
    chk("midrst_memwr", 32'(mem_WR), 0);  chk("midrst_memrd", 32'(mem_RD), 0);
    chk("midrst_ack0", 32'(ack0), 0);     chk("midrst_err", 32'(err), 0);
    chk("midrst_rdata", rdata, 0);        chk("midrst_daddr", mem_DAddr, 0);
    chk("midrst_datain", mem_DataIn, 0);
    req0 = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    do_txn('{1'b0, 1'b0, 32'h10, 32'h0, ref_word(16), 1'b0}, "midrst_read");

    // Port 0 holds req for three reads; port 1 idle.
    for (int k = 0; k < 3; k++) sb.push_back('{port: 1'b0, rdata: ref_word(4 * k), err: 1'b0});
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    nack = 0; waited = 0;
    while (nack < 3 && waited < 20) begin
      @(negedge CLK);
      waited++;
      if (ack0 || ack1) begin
        nack++;
        sb_check($sformatf("b2b%0d", nack));
        chk($sformatf("b2b%0d_cycle", nack), 32'(waited), 32'(3 * nack - 1));
        addr0 = 32'(4 * nack);
      end
    end
    req0 = 1'b0;
    chk("b2b_count", 32'(nack), 3);
    sb.delete();
    @(negedge CLK);

    chk("never_both_acks", 32'(both_ack), 0);
    chk("never_rd_and_wr", 32'(both_mem), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
